iir: RTL and testbench
======================

# iir

Second-order (biquad) IIR filter for the 16-bit audio path, clocked by the system clock and paced by one sample per LRCLK period. It captures a new input sample on an LRCLK falling-edge strobe and computes one filtered output with a sequential multiply-accumulate. It presents the result on the LRCLK rising-edge strobe. Coefficients are run-time inputs, so the same block serves as bandpass, lowpass or resonator.

## Interface
- No parameters; all widths are fixed.
- i_clk  in  1  system clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- lrclk_negedge  in  1  one-cycle strobe on the LRCLK falling edge; this is the sample-capture event.
- lrclk_posedge  in  1  one-cycle strobe on the LRCLK rising edge; this is the output-update event.
- i_valid  in  1  enables sample capture; level-sensitive.
- x_in  in  16  signed input sample, integer.
- b1, b2, b3  in  18  signed feed-forward coefficients for x[n], x[n-1] and x[n-2]; Q2.16 format, where 65536 = 1.0.
- a2, a3  in  18  signed feedback coefficients for y[n-1] and y[n-2]; Q2.16 format.
- audio_out  out  16  signed filtered sample, registered.

## Operation
- Difference equation:
  - y[n] = sat16( round( (b1·x[n] + b2·x[n-1] + b3·x[n-2] + a2·y[n-1] + a3·y[n-2]) / 2^16 ) ).
  - Feedback terms are added; the caller supplies the signs.
- Products are 16×18 giving 34-bit signed values. The accumulator is 40-bit signed, which cannot overflow with 5 terms.
- Rounding: add 2^15 to the accumulator, then arithmetic shift right by 16.
- Saturation: clamp to the range -32768 to 32767.
- State registers: x1, x2, y1 and y2, each 16-bit signed.
  - y1 and y2 hold the saturated y values.
- FSM states: IDLE, MAC, UPD.
  - IDLE: on lrclk_negedge with i_valid=1, latch x_in into x0, clear the accumulator and a 3-bit term index, then go to MAC.
  - MAC: add one product per cycle, in the order b1·x0, b2·x1, b3·x2, a2·y1, a3·y2. After the 5th term, go to UPD.
  - UPD: perform the following, then return to IDLE.
    - Round and saturate into y_reg.
    - Shift the histories: x2←x1, x1←x0, y2←y1, y1←y_reg_new.
- lrclk_negedge with i_valid=0 is ignored; states and histories are unchanged.
- lrclk_negedge arriving while not in IDLE is ignored.
- Coefficient inputs are sampled during MAC. They must be held stable from capture until UPD.
- On lrclk_posedge: audio_out←y_reg.
- lrclk_posedge arriving while a computation is in flight: audio_out takes the current y_reg, which is the previous result.
- Reset: the following are all cleared to 0, and the FSM goes to IDLE.
  - x0, x1, x2, y1, y2, y_reg, the accumulator, the term index and audio_out.
  - Reset during MAC or UPD aborts the computation; no history update occurs.

## Timing
- Capture: x0 is registered on the clock edge where lrclk_negedge=1.
- MAC occupies the following 5 cycles; UPD occupies 1 cycle.
- y_reg is valid 6 cycles after the capture edge.
- audio_out changes only on a cycle with lrclk_posedge=1, one clock after the strobe is seen.
- The required minimum spacing from lrclk_negedge to the next lrclk_posedge is 7 cycles. With a nominal half-period of 20 clocks, the output is always the newest sample.
- Throughput: one sample per LRCLK period.
- audio_out is 0 from reset until the first lrclk_posedge that follows a completed computation.

## Test plan
- Reset and hold:
  - Stimulus: assert i_rst_n=0 mid-MAC, then release.
  - Required: audio_out=0; the next sample is computed from zeroed histories.
  - Stimulus: with i_valid=0, pulse lrclk_negedge and lrclk_posedge.
  - Required: audio_out stays 0.
- Pass-through:
  - Stimulus: b1=65536, all other coefficients 0; inputs 8000, -123, 32767.
  - Required: audio_out 8000, -123, 32767 on successive posedges.
- Delay path:
  - Stimulus: b3=65536, all others 0; inputs 100, 200, 300, 400.
  - Required: output 0, 0, 100, 200.
  - Stimulus: b2=65536 instead.
  - Required: the output is delayed by one sample.
- Feedback decay:
  - Stimulus: b1=65536, a2=32768; impulse 16384 followed by zeros.
  - Required: 16384, 8192, 4096, 2048.
  - Stimulus: a3=-65536 with a2=0.
  - Required: 16384, 0, -16384, 0.
- Rounding and saturation:
  - Stimulus: b1=32768 with inputs 3 and -3.
  - Required: outputs 2 and -1.
  - Stimulus: b1=131071 with inputs 30000 and -30000.
  - Required: outputs 32767 and -32768; y1 holds the saturated value.
- Resonator:
  - Stimulus: b1=67, b2=0, b3=-67, a2=130709, a3=-65400; impulse 8000.
  - Required:
    - First output is round(8000·67/65536) = 8.
    - Second output is round((8·130709)/65536) = 16.
    - The response is a slowly decaying oscillation that never exceeds the 16-bit range.

Source files
------------

// File: rtl/iir_if.sv
// Biquad sample bus: LRCLK strobes, input sample, run-time coefficients and
// the filtered output. The master is the audio path feeding the filter, the
// slave is the filter itself.
interface iir_if;
  logic               lrclk_negedge;
  logic               lrclk_posedge;
  logic               i_valid;
  logic signed [15:0] x_in;
  logic signed [17:0] b1;
  logic signed [17:0] b2;
  logic signed [17:0] b3;
  logic signed [17:0] a2;
  logic signed [17:0] a3;
  logic signed [15:0] audio_out;

  modport master (
    output lrclk_negedge, lrclk_posedge, i_valid, x_in,
    output b1, b2, b3, a2, a3,
    input  audio_out
  );

  modport slave (
    input  lrclk_negedge, lrclk_posedge, i_valid, x_in,
    input  b1, b2, b3, a2, a3,
    output audio_out
  );
endinterface

// File: rtl/iir.sv
// Second-order IIR (biquad) section for the 16-bit audio path.
// A sample is captured on the LRCLK falling-edge strobe, five products are
// accumulated one per clock, then the result is rounded, saturated and the
// x/y histories are shifted. The output register follows the LRCLK rising
// edge strobe, so it always shows the most recently finished result.
module iir (
  input  logic     i_clk,
  input  logic     i_rst_n,
  iir_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    UPD  = 2'd2
  } state_t;

  state_t             state_q;
  logic signed [15:0] x0_q;
  logic signed [15:0] x1_q;
  logic signed [15:0] x2_q;
  logic signed [15:0] y1_q;
  logic signed [15:0] y2_q;
  logic signed [15:0] yReg_q;
  logic signed [39:0] acc_q;
  logic        [2:0]  idx_q;
  logic signed [15:0] audioOut_q;

  logic signed [17:0] coefSel;
  logic signed [15:0] dataSel;
  logic signed [33:0] product;
  logic signed [39:0] acc_d;
  logic signed [39:0] accRnd;
  logic signed [39:0] accShift;
  logic signed [15:0] ySat_d;

  // Pick the coefficient/history pair for the current term, form the
  // product, and prepare both the next accumulator and the rounded,
  // saturated result that UPD will commit.
  always_comb begin
    coefSel = '0;
    dataSel = '0;
    case (idx_q)
      3'd0: begin coefSel = bus.b1; dataSel = x0_q; end
      3'd1: begin coefSel = bus.b2; dataSel = x1_q; end
      3'd2: begin coefSel = bus.b3; dataSel = x2_q; end
      3'd3: begin coefSel = bus.a2; dataSel = y1_q; end
      3'd4: begin coefSel = bus.a3; dataSel = y2_q; end
      default: begin coefSel = '0; dataSel = '0; end
    endcase
    product  = 34'(coefSel) * 34'(dataSel);
    acc_d    = acc_q + 40'(product);
    accRnd   = acc_q + 40'sd32768;
    accShift = accRnd >>> 16;
    if (accShift > 40'sd32767)
      ySat_d = 16'sh7FFF;
    else if (accShift < -40'sd32768)
      ySat_d = 16'sh8000;
    else
      ySat_d = accShift[15:0];
  end

  // Sequencer: capture in IDLE, five MAC cycles, one UPD cycle that commits
  // the result and shifts the histories; output register tracks the LRCLK
  // rising strobe independently of where the sequencer is.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      yReg_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      audioOut_q <= '0;
    end else begin
      if (bus.lrclk_posedge)
        audioOut_q <= yReg_q;
      case (state_q)
        IDLE: begin
          if (bus.lrclk_negedge && bus.i_valid) begin
            x0_q    <= bus.x_in;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd4)
            state_q <= UPD;
        end
        UPD: begin
          yReg_q  <= ySat_d;
          x2_q    <= x1_q;
          x1_q    <= x0_q;
          y2_q    <= y1_q;
          y1_q    <= ySat_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.audio_out = audioOut_q;

endmodule

// File: tb/tb_iir.sv
// Self-checking bench for the biquad: each scenario pushes its expected
// outputs onto a scoreboard queue as samples are driven and pops them when
// the output register updates after an LRCLK rising strobe.
module tb_iir;

  logic clk;
  logic rstN;
  int   total;
  int   bad;
  int   expQ[$];

  iir_if bus();

  iir dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setCoefs(input int c1, input int c2, input int c3,
                          input int f2, input int f3);
    bus.b1 = 18'(c1);
    bus.b2 = 18'(c2);
    bus.b3 = 18'(c3);
    bus.a2 = 18'(f2);
    bus.a3 = 18'(f3);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // One LRCLK period: capture strobe, 19 idle clocks, output strobe, then
  // read the output register half a clock after it was loaded.
  task automatic runSample(input int x, output int got);
    @(negedge clk);
    bus.x_in          = 16'(x);
    bus.i_valid       = 1'b1;
    bus.lrclk_negedge = 1'b1;
    @(negedge clk);
    bus.lrclk_negedge = 1'b0;
    bus.i_valid       = 1'b0;
    repeat (19) @(negedge clk);
    bus.lrclk_posedge = 1'b1;
    @(negedge clk);
    bus.lrclk_posedge = 1'b0;
    got = int'(bus.audio_out);
  endtask

  task automatic test_reset();
    int got;
    int exp;
    setCoefs(65536, 65536, 0, 0, 0);
    applyReset();
    total++;
    if (bus.audio_out !== 16'sd0) begin
      bad++;
      $display("[TB] FAIL reset_out got=%0d want=0", bus.audio_out);
    end
    // start a sample, then abort it mid-MAC
    @(negedge clk);
    bus.x_in          = 16'sd1000;
    bus.i_valid       = 1'b1;
    bus.lrclk_negedge = 1'b1;
    @(negedge clk);
    bus.lrclk_negedge = 1'b0;
    bus.i_valid       = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    bus.lrclk_posedge = 1'b1;
    @(negedge clk);
    bus.lrclk_posedge = 1'b0;
    total++;
    if (bus.audio_out !== 16'sd0) begin
      bad++;
      $display("[TB] FAIL abort_out got=%0d want=0", bus.audio_out);
    end
    // capture strobe with i_valid low must be ignored
    @(negedge clk);
    bus.x_in          = 16'sd999;
    bus.lrclk_negedge = 1'b1;
    @(negedge clk);
    bus.lrclk_negedge = 1'b0;
    repeat (10) @(negedge clk);
    bus.lrclk_posedge = 1'b1;
    @(negedge clk);
    bus.lrclk_posedge = 1'b0;
    total++;
    if (bus.audio_out !== 16'sd0) begin
      bad++;
      $display("[TB] FAIL hold_out got=%0d want=0", bus.audio_out);
    end
    // histories must still be zero: y = x0 + x1 = 7 + 0
    expQ.push_back(7);
    runSample(7, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL post_reset_sample got=%0d want=%0d", got, exp);
    end
  endtask

  task automatic test_passthrough();
    int xs[3]  = '{8000, -123, 32767};
    int exs[3] = '{8000, -123, 32767};
    int got;
    int exp;
    setCoefs(65536, 0, 0, 0, 0);
    applyReset();
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(exs[i]);
      runSample(xs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL passthrough[%0d] got=%0d want=%0d", i, got, exp);
      end
    end
  endtask

  task automatic test_delay();
    int xs[4]   = '{100, 200, 300, 400};
    int exB3[4] = '{0, 0, 100, 200};
    int exB2[4] = '{0, 100, 200, 300};
    int got;
    int exp;
    setCoefs(0, 0, 65536, 0, 0);
    applyReset();
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(exB3[i]);
      runSample(xs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL delay_b3[%0d] got=%0d want=%0d", i, got, exp);
      end
    end
    setCoefs(0, 65536, 0, 0, 0);
    applyReset();
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(exB2[i]);
      runSample(xs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL delay_b2[%0d] got=%0d want=%0d", i, got, exp);
      end
    end
  endtask

  task automatic test_feedback();
    int xs[4]   = '{16384, 0, 0, 0};
    int exA2[4] = '{16384, 8192, 4096, 2048};
    int exA3[4] = '{16384, 0, -16384, 0};
    int got;
    int exp;
    setCoefs(65536, 0, 0, 32768, 0);
    applyReset();
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(exA2[i]);
      runSample(xs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL decay_a2[%0d] got=%0d want=%0d", i, got, exp);
      end
    end
    setCoefs(65536, 0, 0, 0, -65536);
    applyReset();
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(exA3[i]);
      runSample(xs[i], got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL decay_a3[%0d] got=%0d want=%0d", i, got, exp);
      end
    end
  endtask

  task automatic test_round_sat();
    int got;
    int exp;
    setCoefs(32768, 0, 0, 0, 0);
    applyReset();
    expQ.push_back(2);
    expQ.push_back(-1);
    runSample(3, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL round_pos got=%0d want=%0d", got, exp);
    end
    runSample(-3, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL round_neg got=%0d want=%0d", got, exp);
    end
    setCoefs(131071, 0, 0, 0, 0);
    applyReset();
    expQ.push_back(32767);
    expQ.push_back(-32768);
    runSample(30000, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL sat_pos got=%0d want=%0d", got, exp);
    end
    runSample(-30000, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL sat_neg got=%0d want=%0d", got, exp);
    end
    // half of y1: the saturated -32768 gives -16384
    setCoefs(0, 0, 0, 32768, 0);
    expQ.push_back(-16384);
    runSample(0, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL sat_history got=%0d want=%0d", got, exp);
    end
  endtask

  // Output strobe while a computation is running shows the previous result.
  task automatic test_inflight();
    int got;
    int exp;
    setCoefs(65536, 0, 0, 0, 0);
    applyReset();
    expQ.push_back(1234);
    runSample(1234, got);
    exp = expQ.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL inflight_first got=%0d want=%0d", got, exp);
    end
    expQ.push_back(1234);
    expQ.push_back(-555);
    @(negedge clk);
    bus.x_in          = -16'sd555;
    bus.i_valid       = 1'b1;
    bus.lrclk_negedge = 1'b1;
    @(negedge clk);
    bus.lrclk_negedge = 1'b0;
    bus.i_valid       = 1'b0;
    repeat (2) @(negedge clk);
    bus.lrclk_posedge = 1'b1;
    @(negedge clk);
    bus.lrclk_posedge = 1'b0;
    exp = expQ.pop_front();
    total++;
    if (bus.audio_out !== 16'(exp)) begin
      bad++;
      $display("[TB] FAIL inflight_old got=%0d want=%0d", bus.audio_out, exp);
    end
    repeat (10) @(negedge clk);
    bus.lrclk_posedge = 1'b1;
    @(negedge clk);
    bus.lrclk_posedge = 1'b0;
    exp = expQ.pop_front();
    total++;
    if (bus.audio_out !== 16'(exp)) begin
      bad++;
      $display("[TB] FAIL inflight_new got=%0d want=%0d", bus.audio_out, exp);
    end
  endtask

  // Resonator impulse response against an integer difference-equation model.
  task automatic test_resonator();
    longint c1 = 67;
    longint c2 = 0;
    longint c3 = -67;
    longint f2 = 130709;
    longint f3 = -65400;
    longint mx1 = 0;
    longint mx2 = 0;
    longint my1 = 0;
    longint my2 = 0;
    longint acc;
    longint r;
    int x;
    int got;
    int exp;
    setCoefs(67, 0, -67, 130709, -65400);
    applyReset();
    for (int i = 0; i < 24; i++) begin
      x   = (i == 0) ? 8000 : 0;
      acc = c1 * longint'(x) + c2 * mx1 + c3 * mx2 + f2 * my1 + f3 * my2;
      r   = (acc + 64'sd32768) >>> 16;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      mx2 = mx1;
      mx1 = longint'(x);
      my2 = my1;
      my1 = r;
      expQ.push_back(int'(r));
      runSample(x, got);
      exp = expQ.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL resonator[%0d] got=%0d want=%0d", i, got, exp);
      end
    end
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_left got=%0d want=0", expQ.size());
    end
  endtask

  initial begin
    total             = 0;
    bad               = 0;
    rstN              = 1'b0;
    bus.lrclk_negedge = 1'b0;
    bus.lrclk_posedge = 1'b0;
    bus.i_valid       = 1'b0;
    bus.x_in          = '0;
    setCoefs(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    test_reset();
    test_passthrough();
    test_delay();
    test_feedback();
    test_round_sat();
    test_inflight();
    test_resonator();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
